adc_frame_align_ctrl: RTL

- Per-interface frame-alignment sequencer for the LVDS ADC receiver (DCLK/FCLK/DATA, C_AdcWireInt wires per channel).
- Watches the deserialized FCLK word and issues ISERDES reset and single-cycle BitSlip pulses until the word equals the expected frame pattern.
- Then declares alignment and monitors for loss of framing.
- Sits in the SysClk (frame-rate) domain between the MMCM lock output and the deserializer bank. One BitSlip drives all data and frame lanes.

---
 rtl/adc_lvds_pkg.sv | 25 ++
 rtl/adc_align_timer.sv | 27 ++
 rtl/adc_frame_align_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/adc_lvds_pkg.sv
// Shared types and defaults for the LVDS ADC receiver frame-alignment logic.
// Counter widths are derived with cnt_w(): clog2 of the counter's max value plus 1.
package adc_lvds_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        SETTLE,
        CHECK,
        SLIP,
        LOCKED,
        FAIL
    } align_state_t;

    localparam int C_DefFrmBits      = 8;
    localparam int C_DefRstCycles    = 4;
    localparam int C_DefSettleCycles = 4;
    localparam int C_DefMatchCount   = 16;
    localparam int C_DefLossThresh   = 4;

    function automatic int cnt_w(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/adc_align_timer.sv
// Loadable down-counter with count enable; done while the count sits at zero.
module adc_align_timer #(
    parameter int C_Width = 3
) (
    input  logic               SysClk,
    input  logic               SysRst,
    input  logic               load,
    input  logic [C_Width-1:0] load_val,
    input  logic               cnt_en,
    output logic               done
);

    logic [C_Width-1:0] cnt;

    always_ff @(posedge SysClk or negedge SysRst) begin
        if (!SysRst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt_en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/adc_frame_align_ctrl.sv
// Frame-alignment sequencer: resets the ISERDES bank, bit-slips until the FCLK
// word matches the frame pattern, then watches for loss of framing.
module adc_frame_align_ctrl
    import adc_lvds_pkg::*;
#(
    parameter int                   C_FrmBits      = C_DefFrmBits,
    parameter logic [C_FrmBits-1:0] C_FrmPattern   = 8'hF0,
    parameter int                   C_RstCycles    = C_DefRstCycles,
    parameter int                   C_SettleCycles = C_DefSettleCycles,
    parameter int                   C_MatchCount   = C_DefMatchCount,
    parameter int                   C_LossThresh   = C_DefLossThresh
) (
    input  logic                             SysClk,
    input  logic                             SysRst,
    input  logic                             MmcmLocked,
    input  logic                             Start,
    input  logic [C_FrmBits-1:0]             FrmWord,
    input  logic                             FrmValid,
    output logic                             SerdesRst,
    output logic                             BitSlip,
    output logic                             Aligned,
    output logic                             AlignErr,
    output logic [$clog2(C_FrmBits+1)-1:0]   SlipCnt,
    output logic                             Busy
);

    localparam int C_SlipW  = $clog2(C_FrmBits + 1);
    localparam int C_MatchW = cnt_w(C_MatchCount);
    localparam int C_LossW  = cnt_w(C_LossThresh);
    localparam int C_TmrMax = (C_RstCycles > C_SettleCycles) ? C_RstCycles : C_SettleCycles;
    localparam int C_TmrW   = cnt_w(C_TmrMax);

    localparam logic [C_SlipW-1:0]  C_SlipLast   = C_SlipW'(C_FrmBits - 1);
    localparam logic [C_MatchW-1:0] C_MatchLast  = C_MatchW'(C_MatchCount - 1);
    localparam logic [C_LossW-1:0]  C_LossLast   = C_LossW'(C_LossThresh - 1);
    localparam logic [C_TmrW-1:0]   C_RstLoad    = C_TmrW'(C_RstCycles - 1);
    localparam logic [C_TmrW-1:0]   C_SettleLoad = C_TmrW'(C_SettleCycles - 1);

    align_state_t         state;
    align_state_t         state_nxt;
    logic [C_MatchW-1:0]  match_cnt;
    logic [C_LossW-1:0]   loss_cnt;
    logic                 frm_match;
    logic                 enter_rst;
    logic                 tmr_load;
    logic [C_TmrW-1:0]    tmr_load_val;
    logic                 tmr_en;
    logic                 tmr_done;

    function automatic int unsigned sat_inc(input int unsigned val, input int unsigned max_val);
        return (val >= max_val) ? max_val : val + 1;
    endfunction

    assign frm_match    = (FrmWord == C_FrmPattern);
    assign enter_rst    = (state_nxt == RST) && (state != RST);
    assign tmr_load     = (state_nxt != state) && ((state_nxt == RST) || (state_nxt == SETTLE));
    assign tmr_load_val = (state_nxt == RST) ? C_RstLoad : C_SettleLoad;
    assign tmr_en       = (state == RST) || ((state == SETTLE) && FrmValid);

    adc_align_timer #(
        .C_Width (C_TmrW)
    ) u_align_timer (
        .SysClk   (SysClk),
        .SysRst   (SysRst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .cnt_en   (tmr_en),
        .done     (tmr_done)
    );

    // Losing Start or MMCM lock overrides any CHECK/LOCKED decision in the same cycle.
    always_comb begin
        state_nxt = state;
        if (!(Start && MmcmLocked)) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:   state_nxt = RST;
                RST:    if (tmr_done) state_nxt = SETTLE;
                SETTLE: if (FrmValid && tmr_done) state_nxt = CHECK;
                CHECK: begin
                    if (FrmValid) begin
                        if (frm_match) begin
                            if (match_cnt == C_MatchLast) state_nxt = LOCKED;
                        end else if (SlipCnt >= C_SlipLast) begin
                            state_nxt = FAIL;
                        end else begin
                            state_nxt = SLIP;
                        end
                    end
                end
                SLIP:   state_nxt = SETTLE;
                LOCKED: if (FrmValid && !frm_match && (loss_cnt == C_LossLast)) state_nxt = RST;
                FAIL:   state_nxt = FAIL;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they track the state register exactly.
    always_ff @(posedge SysClk or negedge SysRst) begin
        if (!SysRst) begin
            state     <= IDLE;
            SerdesRst <= 1'b1;
            BitSlip   <= 1'b0;
            Aligned   <= 1'b0;
            AlignErr  <= 1'b0;
            Busy      <= 1'b0;
            SlipCnt   <= '0;
            match_cnt <= '0;
            loss_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            SerdesRst <= (state_nxt == IDLE) || (state_nxt == RST);
            BitSlip   <= (state_nxt == SLIP);
            Aligned   <= (state_nxt == LOCKED);
            Busy      <= state_nxt inside {RST, SETTLE, CHECK, SLIP};
            AlignErr  <= (state_nxt == FAIL) || (AlignErr && (state_nxt != RST));
            if (enter_rst) begin
                SlipCnt   <= '0;
                match_cnt <= '0;
                loss_cnt  <= '0;
            end else begin
                if ((state == CHECK) && (state_nxt == SLIP))
                    SlipCnt <= C_SlipW'(sat_inc(32'(SlipCnt), C_FrmBits - 1));
                if ((state == CHECK) && FrmValid)
                    match_cnt <= frm_match ? C_MatchW'(sat_inc(32'(match_cnt), C_MatchCount)) : '0;
                if (state != LOCKED)
                    loss_cnt <= '0;
                else if (FrmValid)
                    loss_cnt <= frm_match ? '0 : C_LossW'(sat_inc(32'(loss_cnt), C_LossThresh));
            end
        end
    end

endmodule
